dot_product_chunk_accumulator: RTL and testbench
================================================

// Module: dot_product_chunk_accumulator
// PURPOSE
//  Downstream of the 8-lane tree-add dot-product stage. Sums NUM_CHUNKS consecutive
//  19-bit partial dot products (one per 8-element chunk) into the dot product of a
//  vector NUM_CHUNKS*8 elements long. Presents the total on a valid/ready output port.
//  Back-pressures the producer while a finished result is waiting for the consumer.
// PARAMETERS
//  IN_W        19   width of each incoming partial dot product (unsigned)
//  NUM_CHUNKS  4    partial results summed per output; legal range 1..256
//  ACC_W       24   accumulator/output width; ACC_W >= IN_W required (elaboration error otherwise)
// PORTS
//  clk        in   1           single clock, rising edge
//  rst_n      in   1           asynchronous active-low reset
//  clr        in   1           sync abort: discard partial sum, drop pending result
//  in_dot     in   IN_W        partial dot product from the tree-add stage
//  in_valid   in   1           in_dot qualifier; one partial per cycle in which in_valid & in_ready
//  in_ready   out  1           accumulator can accept a partial this cycle
//  acc_out    out  ACC_W       accumulated dot product
//  acc_valid  out  1           acc_out holds a complete sum
//  acc_ready  in   1           consumer takes acc_out when acc_valid & acc_ready
//  chunk_cnt  out  8           partials accepted for the current sum
//  acc_ovf    out  1           sticky overflow flag (DOTACC_SAT_EN only; else constant 0)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, acc_out=0, acc_valid=0, chunk_cnt=0, acc_ovf=0, in_ready=1.
//  States: IDLE (no partial held), ACCUM (1..NUM_CHUNKS-1 partials held), HOLD (result pending).
//  in_ready = (state != HOLD) & ~clr. Combinational from state and clr only, never from in_valid.
//  accept = in_valid & in_ready. in_dot is zero-extended to ACC_W.
//  IDLE, accept: acc_out<=in_dot, chunk_cnt<=1, acc_ovf<=0. Next state: HOLD if NUM_CHUNKS==1, else ACCUM.
//  ACCUM, accept: acc_out<=acc_out+in_dot, chunk_cnt++. Next state: HOLD when the new count equals NUM_CHUNKS.
//  No accept: acc_out and chunk_cnt hold. in_valid while in_ready=0 is ignored (not queued).
//  Entering HOLD: acc_valid<=1 on the edge that accepts the last partial.
//    Latency: last partial accepted at edge N -> acc_valid=1 after edge N.
//  HOLD: acc_out, acc_valid, chunk_cnt stable until acc_ready=1. On handshake edge: acc_valid<=0,
//    chunk_cnt<=0, state<=IDLE. acc_out keeps its last value. A new partial is accepted
//    no earlier than the next cycle (1 idle bubble per sum).
//  clr=1 (any state, highest priority after reset): state<=IDLE, chunk_cnt<=0, acc_valid<=0,
//    acc_ovf<=0. acc_out holds. No partial is accepted that cycle.
//  Gaps in in_valid mid-sum are legal. The sum spans exactly NUM_CHUNKS accepted partials.
//  Reset mid-ACCUM/HOLD: partial sum and pending result are lost. No output glitch beyond the reset values.
//  Width: with ACC_W >= IN_W+clog2(NUM_CHUNKS) overflow is impossible. Smaller ACC_W is legal;
//    overflow is then handled per CONFIGURATION.
// CONFIGURATION
//  DOTACC_SAT_EN defined:
//    Each add is computed at ACC_W+1 bits. On carry-out, acc_out <= {ACC_W{1'b1}} and acc_ovf <= 1.
//    Once saturated, acc_out stays saturated for the rest of that sum.
//    acc_ovf clears on the first accept in IDLE, on clr, and on reset.
//  DOTACC_SAT_EN undefined:
//    Addition wraps modulo 2^ACC_W. acc_ovf is tied to 0. No extra adder bit.
// TESTING
//  T1 reset: rst_n=0 mid-run -> acc_out=0, acc_valid=0, chunk_cnt=0, in_ready=1 immediately (async).
//  T2 basic (defaults): partials 100,200,300,400 with 2-cycle gaps, acc_ready=1
//     -> acc_out=1000, acc_valid=1 for exactly 1 cycle, starting the cycle after the 4th accept.
//  T3 backpressure: same partials, acc_ready=0 for 5 cycles, in_valid=1 with in_dot=7 throughout
//     -> acc_out=1000 stable, in_ready=0, the 7s ignored. After acc_ready=1, the next sum starts from 7.
//  T4 clr: accept 50,60, then clr=1 with in_valid=1 -> chunk_cnt=0, not accepted.
//     Then partials 1,1,1,1 -> acc_out=4.
//  T5 max (defaults): four partials of 520200 (8*255*255) -> acc_out=2080800, no overflow.
//  T6 overflow (ACC_W=20): four partials of 520200
//     -> with DOTACC_SAT_EN: acc_out=1048575, acc_ovf=1.
//     -> without: acc_out=1032224, acc_ovf=0.

Source files
------------

// File: rtl/dot_product_chunk_accumulator_if.sv
// Handshake bundle for dot_product_chunk_accumulator: partial-product input port,
// accumulated-result output port, sync abort and status flags.
interface dot_product_chunk_accumulator_if #(
    parameter int IN_W  = 19,
    parameter int ACC_W = 24
);
    logic             clr;
    logic [IN_W-1:0]  in_dot;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] acc_out;
    logic             acc_valid;
    logic             acc_ready;
    logic [7:0]       chunk_cnt;
    logic             acc_ovf;

    modport master (
        output clr, in_dot, in_valid, acc_ready,
        input  in_ready, acc_out, acc_valid, chunk_cnt, acc_ovf
    );

    modport slave (
        input  clr, in_dot, in_valid, acc_ready,
        output in_ready, acc_out, acc_valid, chunk_cnt, acc_ovf
    );
endinterface

// File: rtl/dot_product_chunk_accumulator.sv
// Sums NUM_CHUNKS partial dot products into one result on a valid/ready port.
// Define DOTACC_SAT_EN for saturating adds with a sticky acc_ovf; default build wraps.
module dot_product_chunk_accumulator #(
    parameter int IN_W       = 19,
    parameter int NUM_CHUNKS = 4,
    parameter int ACC_W      = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,
    dot_product_chunk_accumulator_if.slave bus
);

    if (ACC_W < IN_W) begin : g_bad_acc_w
        $error("ACC_W must be >= IN_W");
    end
    if (NUM_CHUNKS < 1 || NUM_CHUNKS > 256) begin : g_bad_num_chunks
        $error("NUM_CHUNKS must be in 1..256");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] in_ext, sum;
    // Nine bits so a count of 256 is representable for the terminal compare.
    logic [8:0]       cnt_q, cnt_d, cnt_inc;
    logic             valid_q, valid_d;
    logic             in_ready, accept;

    assign in_ext   = ACC_W'(bus.in_dot);
    assign cnt_inc  = cnt_q + 9'd1;
    assign in_ready = (state_q != HOLD) && !bus.clr;
    assign accept   = bus.in_valid && in_ready;

`ifdef DOTACC_SAT_EN
    logic             ovf_q, ovf_d, carry;
    logic [ACC_W:0]   sum_wide;

    assign sum_wide = {1'b0, acc_q} + {1'b0, in_ext};
    assign carry    = sum_wide[ACC_W];
    // A saturated accumulator carries out on any nonzero add, so it stays pinned.
    assign sum      = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
    assign sum      = acc_q + in_ext;
`endif

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no path infers a latch.
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
`ifdef DOTACC_SAT_EN
        ovf_d   = ovf_q;
`endif
        if (bus.clr) begin
            state_d = IDLE;
            cnt_d   = 9'd0;
            valid_d = 1'b0;
`ifdef DOTACC_SAT_EN
            ovf_d   = 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: if (accept) begin
                    acc_d = in_ext;
                    cnt_d = 9'd1;
`ifdef DOTACC_SAT_EN
                    ovf_d = 1'b0;
`endif
                    if (NUM_CHUNKS == 1) begin
                        state_d = HOLD;
                        valid_d = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
                ACCUM: if (accept) begin
                    acc_d = sum;
                    cnt_d = cnt_inc;
`ifdef DOTACC_SAT_EN
                    ovf_d = ovf_q | carry;
`endif
                    if (cnt_inc == 9'(NUM_CHUNKS)) begin
                        state_d = HOLD;
                        valid_d = 1'b1;
                    end
                end
                HOLD: if (bus.acc_ready) begin
                    state_d = IDLE;
                    cnt_d   = 9'd0;
                    valid_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= 9'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

`ifdef DOTACC_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end
    assign bus.acc_ovf = ovf_q;
`else
    assign bus.acc_ovf = 1'b0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.acc_out   = acc_q;
    assign bus.acc_valid = valid_q;
    assign bus.chunk_cnt = cnt_q[7:0];

endmodule

// File: tb/tb_dot_product_chunk_accumulator.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level model of the accumulator (default and ACC_W=20 instances).
module tb_dot_product_chunk_accumulator;

    localparam int IN_W  = 19;
    localparam int NC    = 4;
    localparam int ACC_W = 24;
    localparam int OVF_W = 20;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dot_product_chunk_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W)) dif ();
    dot_product_chunk_accumulator_if #(.IN_W(IN_W), .ACC_W(OVF_W)) oif ();

    dot_product_chunk_accumulator #(.IN_W(IN_W), .NUM_CHUNKS(NC), .ACC_W(ACC_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(dif)
    );
    dot_product_chunk_accumulator #(.IN_W(IN_W), .NUM_CHUNKS(NC), .ACC_W(OVF_W)) u_ovf (
        .clk(clk), .rst_n(rst_n), .bus(oif)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: partials accepted so far, whether a result awaits the consumer, visible acc_out.
    int     m_cnt     = 0;
    bit     m_pending = 1'b0;
    longint m_acc     = 0;

    task automatic drive(input bit v, input int d, input bit rdy, input bit c);
        dif.in_valid  = v;
        dif.in_dot    = IN_W'(d);
        dif.acc_ready = rdy;
        dif.clr       = c;
    endtask

    task automatic model_reset();
        m_cnt = 0; m_pending = 1'b0; m_acc = 0;
    endtask

    // One clock of the default instance: check in_ready, advance model, check outputs.
    task automatic step(input string tag);
        bit exp_ready;
        #1;
        exp_ready = !m_pending && !dif.clr;
        n_tests++;
        if (dif.in_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL %s in_ready: got %0b expected %0b", tag, dif.in_ready, exp_ready);
        end
        if (dif.clr) begin
            m_cnt = 0; m_pending = 1'b0;
        end else if (m_pending) begin
            if (dif.acc_ready) begin m_cnt = 0; m_pending = 1'b0; end
        end else if (dif.in_valid) begin
            m_acc = (m_cnt == 0) ? longint'(dif.in_dot)
                                 : (m_acc + longint'(dif.in_dot)) % (longint'(1) << ACC_W);
            m_cnt++;
            if (m_cnt == NC) m_pending = 1'b1;
        end
        @(posedge clk); #1;
        n_tests++;
        if (dif.acc_valid !== m_pending || dif.chunk_cnt !== 8'(m_cnt) ||
            dif.acc_out !== ACC_W'(m_acc) || dif.acc_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL %s outputs: got valid=%0b cnt=%0d out=%0d ovf=%0b expected valid=%0b cnt=%0d out=%0d ovf=0",
                     tag, dif.acc_valid, dif.chunk_cnt, dif.acc_out, dif.acc_ovf,
                     m_pending, m_cnt, m_acc);
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_tests++;
        if (dif.acc_out !== '0 || dif.acc_valid !== 1'b0 || dif.chunk_cnt !== 8'd0 ||
            dif.in_ready !== 1'b1 || dif.acc_ovf !== 1'b0 || oif.acc_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got out=%0d valid=%0b cnt=%0d ready=%0b ovf=%0b/%0b expected 0,0,0,1,0/0",
                     tag, dif.acc_out, dif.acc_valid, dif.chunk_cnt, dif.in_ready,
                     dif.acc_ovf, oif.acc_ovf);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        oif.in_valid = 1'b0; oif.in_dot = '0; oif.acc_ready = 1'b0; oif.clr = 1'b0;
        #3;
        check_reset_values("reset_initial");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        int parts[4] = '{100, 200, 300, 400};
        for (int i = 0; i < 4; i++) begin
            drive(1, parts[i], 1, 0);
            step("basic_accept");
            if (i == 3) begin
                n_tests++;
                if (dif.acc_out !== 24'd1000 || dif.acc_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL basic_sum: got out=%0d valid=%0b expected 1000 valid=1",
                             dif.acc_out, dif.acc_valid);
                end
            end
            drive(0, 0, 1, 0);
            step("basic_gap");
            if (i == 3) begin
                n_tests++;
                if (dif.acc_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_valid_one_cycle: got valid=%0b expected 0", dif.acc_valid);
                end
            end
            step("basic_gap");
        end
    endtask

    task automatic test_backpressure();
        int parts[4] = '{100, 200, 300, 400};
        for (int i = 0; i < 4; i++) begin
            drive(1, parts[i], 0, 0);
            step("bp_accept");
            drive(0, 0, 0, 0);
            step("bp_gap");
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 7, 0, 0);
            step("bp_stall");
            n_tests++;
            if (dif.in_ready !== 1'b0 || dif.acc_out !== 24'd1000 || dif.acc_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold: got ready=%0b out=%0d valid=%0b expected 0 1000 1",
                         dif.in_ready, dif.acc_out, dif.acc_valid);
            end
        end
        drive(1, 7, 1, 0);
        step("bp_handshake");
        step("bp_first7");
        n_tests++;
        if (dif.acc_out !== 24'd7 || dif.chunk_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL bp_restart: got out=%0d cnt=%0d expected 7 1", dif.acc_out, dif.chunk_cnt);
        end
        repeat (3) step("bp_more7");
        n_tests++;
        if (dif.acc_out !== 24'd28 || dif.acc_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second_sum: got out=%0d valid=%0b expected 28 1", dif.acc_out, dif.acc_valid);
        end
        drive(0, 0, 1, 0);
        step("bp_drain");
    endtask

    task automatic test_clr();
        drive(1, 50, 1, 0); step("clr_50");
        drive(1, 60, 1, 0); step("clr_60");
        drive(1, 99, 1, 1); step("clr_abort");
        n_tests++;
        if (dif.chunk_cnt !== 8'd0 || dif.acc_valid !== 1'b0 || dif.acc_out !== 24'd110) begin
            n_fail++;
            $display("FAIL clr_state: got cnt=%0d valid=%0b out=%0d expected 0 0 110",
                     dif.chunk_cnt, dif.acc_valid, dif.acc_out);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0); step("clr_ones");
        end
        n_tests++;
        if (dif.acc_out !== 24'd4 || dif.acc_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_resum: got out=%0d valid=%0b expected 4 1", dif.acc_out, dif.acc_valid);
        end
        drive(0, 0, 1, 0); step("clr_drain");
    endtask

    task automatic test_max();
        for (int i = 0; i < 4; i++) begin
            drive(1, 520200, 0, 0); step("max_accept");
        end
        n_tests++;
        if (dif.acc_out !== 24'd2080800 || dif.acc_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL max_sum: got out=%0d ovf=%0b expected 2080800 0", dif.acc_out, dif.acc_ovf);
        end
        drive(0, 0, 1, 0); step("max_drain");
        step("max_idle");
    endtask

    task automatic test_overflow();
        longint s = 0;
        longint exp_out;
        bit     exp_ovf = 1'b0;
        for (int i = 0; i < 4; i++) s += 520200;
`ifdef DOTACC_SAT_EN
        if (s >= (longint'(1) << OVF_W)) exp_ovf = 1'b1;
        exp_out = exp_ovf ? (longint'(1) << OVF_W) - 1 : s;
`else
        exp_out = s % (longint'(1) << OVF_W);
`endif
        oif.acc_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            oif.in_valid = 1'b1; oif.in_dot = IN_W'(520200);
            @(posedge clk); #1;
        end
        oif.in_valid = 1'b0;
        #1;
        n_tests++;
        if (oif.acc_out !== OVF_W'(exp_out) || oif.acc_ovf !== exp_ovf || oif.acc_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sum: got out=%0d ovf=%0b valid=%0b expected %0d %0b 1",
                     oif.acc_out, oif.acc_ovf, oif.acc_valid, exp_out, exp_ovf);
        end
        oif.clr = 1'b1;
        @(posedge clk); #1;
        oif.clr = 1'b0;
        #1;
        n_tests++;
        if (oif.acc_ovf !== 1'b0 || oif.acc_valid !== 1'b0 || oif.chunk_cnt !== 8'd0 ||
            oif.acc_out !== OVF_W'(exp_out)) begin
            n_fail++;
            $display("FAIL ovf_clr: got ovf=%0b valid=%0b cnt=%0d out=%0d expected 0 0 0 %0d",
                     oif.acc_ovf, oif.acc_valid, oif.chunk_cnt, oif.acc_out, exp_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 10) < 6, int'($urandom_range(0, (1 << IN_W) - 1)),
                  $urandom % 2, ($urandom % 20) == 0);
            step("random");
        end
        drive(0, 0, 1, 0);
        step("random_drain");
    endtask

    task automatic test_reset_midrun();
        drive(1, 123, 0, 0); step("rst_mid_a");
        drive(1, 456, 0, 0); step("rst_mid_b");
        drive(0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("reset_mid_accum");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 9, 0, 0); step("rst_hold_fill");
        end
        drive(0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("reset_mid_hold");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 5, 1, 0); step("rst_after");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_clr();
        test_max();
        test_overflow();
        test_random();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
